// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the RV32I execute stage and a
// word-wide data RAM with combinational read. Byte, half and word accesses
// at byte addresses become word RAM accesses. Sub-word stores use a
// read-modify-write. Misaligned, illegal-size and out-of-range requests get
// an error response without touching memory. Only one request is in flight.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RMW   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [2:0]            state;
  logic [2:0]            state_nxt;

  // Fields of the accepted request; the request inputs are ignored once
  // the controller leaves IDLE.
  logic                  cap_err;
  logic                  cap_unsigned;
  logic [1:0]            cap_size;
  logic [1:0]            cap_off;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [15:0]           cap_wdata;

  logic [31:0]           load_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_word_store;

  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_val;
  logic [31:0]           merged;

  assign req_ready      = (state == S_IDLE) && !rst;
  assign accept         = req_valid && req_ready;
  assign req_idx        = req_addr[ADDR_WIDTH+1:2];
  assign req_word_store = req_we && (req_size == SZ_WORD);

  assign mem_we    = (state == S_WRITE) && !rst;
  assign rsp_valid = (state == S_RESP) && !rst;
  assign rsp_err   = rsp_valid && cap_err;
  assign rsp_rdata = rsp_valid ? load_q : 32'd0;

  // Classify the incoming request; the first matching rule is enough to
  // reject it, and out-of-range means any byte-address bit above the RAM.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL) begin
      req_err = 1'b1;
    end else if ((req_size == SZ_HALF) && req_addr[0]) begin
      req_err = 1'b1;
    end else if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end else if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
      req_err = 1'b1;
    end
  end

  // Sequence: errors answer straight away, loads read once, word stores
  // write once, sub-word stores read then write.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nxt = S_RESP;
          end else if (!req_we) begin
            state_nxt = S_LOAD;
          end else if (req_size == SZ_WORD) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_RMW;
          end
        end
      end
      S_LOAD:  state_nxt = S_RESP;
      S_RMW:   state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pick the addressed byte and half out of the RAM word (little-endian).
  always_comb begin
    lane_b = mem_rdata[7:0];
    case (cap_off)
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Right-justify the load result and extend it per the signedness flag.
  always_comb begin
    load_val = mem_rdata;
    case (cap_size)
      SZ_BYTE: load_val = cap_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_val = cap_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  // Replace just the target lane of the current RAM word with store data.
  always_comb begin
    merged = mem_rdata;
    if (cap_size == SZ_HALF) begin
      if (cap_off[1]) begin
        merged[31:16] = cap_wdata;
      end else begin
        merged[15:0] = cap_wdata;
      end
    end else begin
      case (cap_off)
        2'd0: merged[7:0]   = cap_wdata[7:0];
        2'd1: merged[15:8]  = cap_wdata[7:0];
        2'd2: merged[23:16] = cap_wdata[7:0];
        2'd3: merged[31:24] = cap_wdata[7:0];
        default: merged = mem_rdata;
      endcase
    end
  end

  // State register; reset drops any pending request without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the request at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_err      <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= 2'b00;
      cap_off      <= 2'b00;
      cap_idx      <= '0;
      cap_wdata    <= 16'd0;
    end else if (accept) begin
      cap_err      <= req_err;
      cap_unsigned <= req_unsigned;
      cap_size     <= req_size;
      cap_off      <= req_addr[1:0];
      cap_idx      <= req_idx;
      cap_wdata    <= req_wdata[15:0];
    end
  end

  // Read address is loaded at accept so it is stable through LOAD/RMW and
  // holds afterwards; stores that need no read leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_raddr <= '0;
    end else if (accept && !req_err && !req_word_store) begin
      mem_raddr <= req_idx;
    end
  end

  // Write address/data are loaded just before WRITE, either straight from a
  // word store or from the merged RMW word, and hold until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
    end else if (accept && !req_err && req_word_store) begin
      mem_waddr <= req_idx;
      mem_wdata <= req_wdata;
    end else if (state == S_RMW) begin
      mem_waddr <= cap_idx;
      mem_wdata <= merged;
    end
  end

  // Load result register; cleared at accept so stores and errors return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 32'd0;
    end else if (accept) begin
      load_q <= 32'd0;
    end else if (state == S_LOAD) begin
      load_q <= load_val;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized checks of lsu_mem_ctrl against a
// word-array reference memory and arithmetic lane rules.
module tb_lsu_mem_ctrl;

  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          mem_we;

  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  int checks;
  int failures;
  logic [31:0] last_rdata;

  lsu_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench RAM: combinational read, write on the clock edge while mem_we.
  assign mem_rdata = ram[mem_raddr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one request, follow it to its response and compare everything
  // against the reference memory. With hold=1 req_valid stays high.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
    logic          exp_err;
    int            exp_lat;
    logic [31:0]   exp_rdata;
    logic [31:0]   old_w;
    logic [31:0]   new_w;
    logic [31:0]   v;
    int            sh;
    logic [AW-1:0] idx;
    int            n;
    int            we_cnt;
    int            ready_bad;
    logic          got;
    logic [31:0]   got_rdata;
    logic          got_err;
    logic [31:0]   wa;
    logic [31:0]   wd;

    idx = addr[AW+1:2];
    sh  = 8 * int'(addr[1:0]);
    exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 0);
    exp_lat   = exp_err ? 1 : (!we ? 2 : (size == 2'b10 ? 2 : 3));
    exp_rdata = 32'd0;
    new_w     = 32'd0;
    if (!exp_err) begin
      old_w = ref_mem[idx];
      if (!we) begin
        if (size == 2'b00) begin
          v = (old_w >> sh) & 32'hFF;
          if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
          v = (old_w >> sh) & 32'hFFFF;
          if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
          v = old_w;
        end
        exp_rdata = v;
      end else begin
        if (size == 2'b10)      new_w = wdata;
        else if (size == 2'b01) new_w = (old_w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
        else                    new_w = (old_w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        ref_mem[idx] = new_w;
      end
    end

    @(negedge clk);
    checkOutput("ready_idle", {31'd0, req_ready}, 32'd1);
    checkOutput("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid    = hold;
    req_wdata    = $urandom;
    req_addr     = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    req_we       = 1'($urandom_range(0, 1));
    req_unsigned = 1'($urandom_range(0, 1));

    n = 0; we_cnt = 0; ready_bad = 0; got = 1'b0;
    got_rdata = 32'd0; got_err = 1'b0; wa = 32'd0; wd = 32'd0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      if (req_ready) ready_bad++;
      if (mem_we) begin
        we_cnt++;
        wa = 32'(mem_waddr);
        wd = mem_wdata;
      end
      if (rsp_valid) begin
        got       = 1'b1;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
      end
    end
    if (!got) n = 99;
    last_rdata = got_rdata;

    checkOutput("latency", n, exp_lat);
    checkOutput("rsp_err", {31'd0, got_err}, {31'd0, exp_err});
    checkOutput("rsp_rdata", got_rdata, exp_rdata);
    checkOutput("mem_we_count", we_cnt, (we && !exp_err) ? 1 : 0);
    checkOutput("ready_busy", ready_bad, 0);
    if (we && !exp_err) begin
      checkOutput("mem_waddr", wa, 32'(idx));
      checkOutput("mem_wdata", wd, new_w);
      checkOutput("ram_word", ram[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] mism;
    checks = 0;
    failures = 0;
    last_rdata = 32'd0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_raddr", 32'(mem_raddr), 32'd0);
    checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    $display("[TB] preset words 0..63");
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0);

    $display("[TB] word store/load");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    checkOutput("tp1_ram", ram[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    checkOutput("tp1_load", last_rdata, 32'hDEADBEEF);

    $display("[TB] byte store read-modify-write");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 1'b0);
    checkOutput("tp2_ram", ram[8], 32'h11AA3344);

    $display("[TB] sub-word loads with extension");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 1'b0);
    checkOutput("tp3_sbyte", last_rdata, 32'hFFFFFFFF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0);
    checkOutput("tp3_uhalf", last_rdata, 32'h000080FF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0);
    checkOutput("tp3_shalf", last_rdata, 32'h00007F01);

    $display("[TB] error responses");
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h00004000, 32'h0, 1'b0);
    checkOutput("tp4_ram_intact", ram[8], 32'h11AA3344);

    $display("[TB] continuous req_valid");
    for (int i = 0; i < 20; i++) begin
      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end
    req_valid = 1'b0;

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    $display("[TB] reset during write");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h50, 32'h55667788, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h51;
    req_wdata = 32'h00000099;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_write_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_write_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_hold_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    checkOutput("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_ram_intact", ram[20], 32'h55667788);

    mism = 32'd0;
    for (int i = 0; i < 64; i++) begin
      if (ram[i] !== ref_mem[i]) mism++;
    end
    checkOutput("ram_final", mism, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
